uart_tx_scheduler: RTL

Shares one UART transmit line and one baud rate generator among `NUM_REQ` byte requesters. Round-robin arbitration picks a requester, latches its byte and pulses `start_tx` to realign the baud generator. The block then serializes an 8N1 frame (start bit, 8 data bits LSB first, stop bit), counting `SAMPLE_RATE` oversampled ticks per bit. It sits between the command/status producers and the `tx` pin, next to the baud rate generator whose `tick` it consumes.

---
 rtl/uart_pkg.sv | 14 +
 rtl/round_robin_arbiter.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and default frame constants for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

   localparam int UART_DATA_BITS   = 8;
   localparam int UART_SAMPLE_RATE = 16;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward from last+1.
module round_robin_arbiter #(
   parameter int N  = 4,
   parameter int LW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [LW-1:0] last_i,
   output logic [N-1:0]  winner_o,
   output logic [LW-1:0] idx_o
);

   always_comb begin
      int   j;
      logic found;
      winner_o = '0;
      idx_o    = '0;
      found    = 1'b0;
      j        = 0;
      // k runs 1..N so the previous winner is considered last.
      for (int k = 1; k <= N; k++) begin
         j = (int'(last_i) + k) % N;
         if (!found && req_i[j]) begin
            found       = 1'b1;
            winner_o[j] = 1'b1;
            idx_o       = LW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared 8N1 transmitter: grants one requester per frame and serializes its byte
// on tick_i, pulsing start_tx_o so the baud generator realigns to the frame.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int SAMPLE_RATE = UART_SAMPLE_RATE,
   parameter int DATA_BITS   = UART_DATA_BITS
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_i,
   input  logic [NUM_REQ-1:0][DATA_BITS-1:0] data_i,
   input  logic                              tick_i,
   output logic                              start_tx_o,
   output logic [NUM_REQ-1:0]                grant_o,
   output logic                              tx_o,
   output logic                              busy_o,
   output uart_tx_state_t                    state_o
);

   localparam int CW = $clog2(SAMPLE_RATE);
   localparam int BW = $clog2(DATA_BITS);
   localparam int LW = $clog2(NUM_REQ);

   // Handshake: a requester holds req_i high with data_i stable; the byte is taken
   // in the IDLE cycle where it wins, and grant_o pulses for one cycle just after.
   uart_tx_state_t       state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [LW-1:0]        last_q, last_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic                 start_q, start_d;

   logic [NUM_REQ-1:0]   win_onehot;
   logic [LW-1:0]        win_idx;
   logic                 tick_ok;
   logic                 bit_done;

   round_robin_arbiter #(.N(NUM_REQ), .LW(LW)) u_arb (
      .req_i    (req_i),
      .last_i   (last_q),
      .winner_o (win_onehot),
      .idx_o    (win_idx)
   );

   // A tick coincident with start_tx is swallowed by the baud counter clear.
   assign tick_ok  = tick_i & ~start_q;
   assign bit_done = tick_ok && (cnt_q == CW'(SAMPLE_RATE - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      last_d  = last_q;
      grant_d = '0;
      start_d = 1'b0;
      tx_o    = 1'b1;
      if (state_q != IDLE && tick_ok) begin
         cnt_d = bit_done ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               shift_d = data_i[win_idx];
               last_d  = win_idx;
               grant_d = win_onehot;
               start_d = 1'b1;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            tx_o = 1'b0;
            if (bit_done) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            tx_o = shift_q[0];
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         STOP: begin
            tx_o = 1'b1;
            if (bit_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         last_q  <= LW'(NUM_REQ - 1);
         grant_q <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         start_q <= start_d;
      end
   end

   assign busy_o     = (state_q != IDLE);
   assign grant_o    = grant_q;
   assign start_tx_o = start_q;
   assign state_o    = state_q;

endmodule
